// File: rtl/calc_trans.sv
`default_nettype none
// ============================================================================
// Module   : calc_trans
// Purpose  : Per-pixel transmission estimate t = 1 - omega*min(R,G,B)/A,
//            clamped to T0, with a double-buffered atmospheric light.
// Revision : 1.0 - initial release
// ============================================================================
module calc_trans #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int OMEGA_Q8   = 243,
    parameter int T0         = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vsync,
    input  logic                  hsync,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] r_in,
    input  logic [DATA_WIDTH-1:0] g_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic [DATA_WIDTH-1:0] A_in,
    input  logic                  A_valid,
    output logic [DATA_WIDTH-1:0] t_out,
    output logic                  valid_out,
    output logic                  vsync_out,
    output logic                  hsync_out
);

    localparam int c_QW  = 2 * DATA_WIDTH;
    localparam int c_LAT = 2 * DATA_WIDTH + 3;
    localparam logic [DATA_WIDTH-1:0] c_MAX   = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] c_ONE   = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_OMEGA = DATA_WIDTH'(OMEGA_Q8);
    localparam logic [DATA_WIDTH-1:0] c_T0    = DATA_WIDTH'(T0);

    // Frame geometry is informational; the datapath is line-length agnostic.
    if (IMG_WIDTH < 1 || IMG_HEIGHT < 1) begin : g_bad_geometry
    end

    // ------------------------------------------------------------------
    // Atmospheric light: staged in r_a_next, committed on vsync rise
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_a_next;
    logic [DATA_WIDTH-1:0] r_a_cur;
    logic                  r_vsync_d;
    logic [DATA_WIDTH-1:0] w_a_in_nz;
    logic [DATA_WIDTH-1:0] w_a_cur_nxt;
    logic                  w_vs_rise;

    always_comb begin
        w_a_in_nz   = (A_in == '0) ? c_ONE : A_in;
        w_vs_rise   = vsync & ~r_vsync_d;
        w_a_cur_nxt = r_a_cur;
        if (w_vs_rise) begin
            w_a_cur_nxt = A_valid ? w_a_in_nz : r_a_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_next  <= c_MAX;
            r_a_cur   <= c_MAX;
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_a_cur   <= w_a_cur_nxt;
            if (A_valid) begin
                r_a_next <= w_a_in_nz;
            end
        end
    end

    // ------------------------------------------------------------------
    // Qualifier / sync shift registers, same depth as the datapath
    // ------------------------------------------------------------------
    logic [c_LAT-1:0] r_vld;
    logic [c_LAT-1:0] r_hs;
    logic [c_LAT-1:0] r_vs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_hs  <= '0;
            r_vs  <= '0;
        end else begin
            r_vld <= {r_vld[c_LAT-2:0], valid_in};
            r_hs  <= {r_hs[c_LAT-2:0], hsync};
            r_vs  <= {r_vs[c_LAT-2:0], vsync};
        end
    end

    assign valid_out = r_vld[c_LAT-1];
    assign hsync_out = r_hs[c_LAT-1];
    assign vsync_out = r_vs[c_LAT-1];

    // ------------------------------------------------------------------
    // S1: dark channel; the pixel carries the A it will be divided by.
    // The post-update A is used so a frame's first pixel sees the new A.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_min_rg;
    logic [DATA_WIDTH-1:0] w_dark;
    logic [DATA_WIDTH-1:0] r_dark;
    logic [DATA_WIDTH-1:0] r_a_s1;

    always_comb begin
        w_min_rg = (r_in < g_in) ? r_in : g_in;
        w_dark   = (b_in < w_min_rg) ? b_in : w_min_rg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dark <= '0;
            r_a_s1 <= c_MAX;
        end else begin
            r_dark <= w_dark;
            r_a_s1 <= w_a_cur_nxt;
        end
    end

    // ------------------------------------------------------------------
    // S2..S18: product, then restoring divide one quotient bit per stage.
    // r_x holds the unconsumed dividend bits above the quotient bits.
    // ------------------------------------------------------------------
    logic [c_QW-1:0]       r_x       [0:c_QW];
    logic [DATA_WIDTH-1:0] r_rem     [0:c_QW-1];
    logic [DATA_WIDTH-1:0] r_den     [0:c_QW-1];
    logic [DATA_WIDTH:0]   w_trial   [1:c_QW];
    logic [c_QW:1]         w_ge;
    logic [DATA_WIDTH-1:0] w_rem_nxt [1:c_QW-1];

    always_comb begin
        for (int i = 1; i <= c_QW; i++) begin
            w_trial[i] = {r_rem[i-1], r_x[i-1][c_QW-1]};
            w_ge[i]    = (w_trial[i] >= {1'b0, r_den[i-1]});
        end
        for (int i = 1; i < c_QW; i++) begin
            w_rem_nxt[i] = w_ge[i] ? DATA_WIDTH'(w_trial[i] - {1'b0, r_den[i-1]})
                                   : w_trial[i][DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= c_QW; i++) begin
                r_x[i] <= '0;
            end
            for (int i = 0; i < c_QW; i++) begin
                r_rem[i] <= '0;
                r_den[i] <= c_MAX;
            end
        end else begin
            r_x[0]   <= c_QW'(r_dark) * c_QW'(c_OMEGA);
            r_rem[0] <= '0;
            r_den[0] <= r_a_s1;
            for (int i = 1; i <= c_QW; i++) begin
                r_x[i] <= {r_x[i-1][c_QW-2:0], w_ge[i]};
            end
            for (int i = 1; i < c_QW; i++) begin
                r_rem[i] <= w_rem_nxt[i];
                r_den[i] <= r_den[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // S19: saturate quotient, invert, clamp to the floor
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] w_q_sat;
    logic [DATA_WIDTH-1:0] w_t;

    always_comb begin
        w_q_sat = (|r_x[c_QW][c_QW-1:DATA_WIDTH]) ? c_MAX : r_x[c_QW][DATA_WIDTH-1:0];
        w_t     = c_MAX - w_q_sat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_out <= '0;
        end else begin
            t_out <= (w_t < c_T0) ? c_T0 : w_t;
        end
    end

endmodule
`default_nettype wire

// File: doc/calc_trans.md
Name: calc_trans

Overview:
- Per-pixel transmission-map estimator for the dark-channel-prior dehaze pipeline.
- Sits directly downstream of the atmospheric-light estimator and consumes its A_val/valid_out pair.
- Computes t = 1 - omega * min(R,G,B) / A for every pixel of the video stream, clamped to a floor T0.
- Emits t with stream-aligned sync/valid to the recovery stage.

Parameters:
- DATA_WIDTH, 8, width of each colour channel, of A and of t.
- IMG_WIDTH, 320, active pixels per line; informational, used only by bench checks.
- IMG_HEIGHT, 240, active lines per frame; informational.
- OMEGA_Q8, 243, haze-retention factor omega in Q0.8 (243 = 0.95).
- T0, 26, lower clamp for t (26 ≈ 0.1 × 255).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- vsync  in  1  frame sync, aligned with pixel stream.
- hsync  in  1  line sync, aligned with pixel stream.
- valid_in  in  1  pixel qualifier.
- r_in  in  DATA_WIDTH  red.
- g_in  in  DATA_WIDTH  green.
- b_in  in  DATA_WIDTH  blue.
- A_in  in  DATA_WIDTH  atmospheric light from the A estimator.
- A_valid  in  1  one-cycle strobe: A_in is a new estimate.
- t_out  out  DATA_WIDTH  transmission, 0..255 scale.
- valid_out  out  1  t_out qualifier.
- vsync_out  out  1  vsync delayed by LATENCY.
- hsync_out  out  1  hsync delayed by LATENCY.

Behaviour:
- Reset state:
  - All outputs 0.
  - Every pipeline valid/sync bit 0.
  - A_next = 255, A_cur = 255.
  - vsync_d (edge detector) = 0.
- A handling (double-buffered):
  - A_valid=1 loads A_next <= A_in.
  - On vsync rising edge (vsync=1, vsync_d=0), A_cur <= A_next. If A_valid is high in the same cycle, A_cur <= A_in directly, so the fresh value wins.
  - A_in = 0 is stored as 1; the divider never sees 0.
  - A_cur never changes mid-frame.
- Pipeline:
  - Fully pipelined, no backpressure, accepts one pixel per cycle.
  - LATENCY = 2*DATA_WIDTH + 3 = 19 cycles for the default.
  - A pixel sampled at edge k appears on t_out/valid_out after edge k+19.
  - S1: dark = min(r,g,b); capture A_cur into the pixel's sideband.
  - S2: prod = dark * OMEGA_Q8, 2*DATA_WIDTH bits (16).
  - S3..S18: restoring divider, one quotient bit per stage, MSB first. 16-bit quotient q = floor(prod / A), exact.
  - S19: q_sat = min(q, 255); t = 255 - q_sat; t_out = max(t, T0).
- Valid and sync:
  - valid, hsync and vsync each travel through an identical 19-deep shift, so bubbles and sync timing are preserved exactly.
  - Datapath registers may update when valid=0. t_out is only defined when valid_out=1.
- Boundaries:
  - dark > A: q > 255, saturates, t_out = T0.
  - dark = 0: t_out = 255.
  - Back-to-back frames: the A swap happens at each vsync rise.
  - Pixels already in flight keep the A they captured in S1.
- Reset mid-operation:
  - All valid/sync pipeline bits clear immediately (asynchronous).
  - valid_out = 0 while rst is high and during the first 19 cycles after release, until new pixels flush through.
  - A_cur/A_next return to 255.

Test Plan:
- Reset check: assert rst, drive random inputs -> t_out = 0, valid_out = 0, vsync_out = 0; the first frame after release uses A = 255.
- Black pixel: A = 255, r=g=b=0, valid_in=1 at edge k -> valid_out=1 and t_out=255 at edge k+19, with no earlier valid_out.
- Nominal arithmetic:
  - Stimulus: A_valid with A_in=200, then a vsync rise, then pixel (100,150,120).
  - dark=100, prod=24300, q=121 -> t_out=134.
- Saturation and clamp:
  - A=50, pixel (200,220,210): q=972, saturates to 255 -> t_out=26.
  - A_in=0 loaded: pixel dark=0 -> t_out=255; dark=1 -> q=243 -> t_out=26 (255-243=12 < T0).
- A timing:
  - A_valid mid-frame with A_in=100: the current frame still uses the old A.
  - A_valid coincident with the vsync rise: the new A applies from that frame's first pixel.
  - Check with pixel dark=100: t_out=134 under A=200, t_out=26 under A=100 (q=243 → 12, clamped).
- Stream integrity and mid-run reset:
  - Full 320x240 frame with random valid gaps -> valid_out/hsync_out/vsync_out equal the inputs delayed exactly 19 cycles.
  - Every t_out matches the reference model.
  - rst pulse mid-line -> valid_out drops immediately and no stale pixels emerge after release.
